bcd_down_counter: RTL and testbench
===================================

BCD_DOWN_COUNTER -- requirements
Module: bcd_down_counter

Interface
REQ-001 CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 CLR  input  1  reset, synchronous, active-high; sampled on CLK rising edge.
REQ-003 LOAD  input  1  synchronous parallel-load request, active-high.
REQ-004 ENP  input  1  count enable (parallel), active-high.
REQ-005 ENT  input  1  count enable (trickle/cascade), active-high; also gates TC.
REQ-006 PRE  input  4  parallel-load value, BCD or raw 4-bit.
REQ-007 Q  output  4  counter state, registered.
REQ-008 TC  output  1  terminal count (borrow-ahead), combinational: ENT & (Q == 0).
REQ-009 BORROW  output  1  registered one-cycle pulse marking a 0->9 wrap.

Function
REQ-010 Priority per edge SHALL be: CLR > LOAD > count > hold.
REQ-011 LOAD=1 (CLR=0) SHALL set Q <= PRE on the next edge, independent of ENP/ENT.
REQ-012 Count condition SHALL be CLR=0, LOAD=0, ENP=1, ENT=1.
REQ-013 When counting, Q in 1..9 SHALL decrement by 1.
REQ-014 When counting, Q=0 SHALL wrap to 9 (no-saturate build) and set BORROW=1 on that same edge.
REQ-015 When counting, illegal Q in 10..15 SHALL load 9 on the next edge; BORROW stays 0.
REQ-016 Illegal PRE (10..15) SHALL still load verbatim; recovery follows REQ-015 on the next count.
REQ-017 Neither enable asserted (LOAD=0) SHALL hold Q; BORROW SHALL be 0.
REQ-018 BORROW SHALL be high for exactly one cycle per wrap; consecutive wraps (every 10 counts) each produce one pulse.
REQ-019 TC SHALL be 1 whenever Q=0 and ENT=1, regardless of ENP, LOAD, or count activity, so cascaded stages decrement only on their lower stage's TC.
REQ-020 Load and count simultaneously requested SHALL result in load only; BORROW SHALL be 0 on that edge.
REQ-021 Latency: Q and BORROW change one edge after qualifying inputs; TC follows Q and ENT combinationally with no added register.
REQ-022 Outputs SHALL never be X after the first reset edge.

Reset
REQ-023 CLR=1 on an edge SHALL force Q=0 and BORROW=0, overriding LOAD and enables.
REQ-024 CLR asserted mid-count SHALL abort the count on that edge; no BORROW pulse for that edge.
REQ-025 After reset release, Q=0; with ENT=1, TC=1 immediately.
REQ-026 Before the first CLR edge, Q and BORROW are undefined; no function is guaranteed.

Configuration
REQ-027 Macro BCD_DOWN_COUNTER_SATURATE_EN SHALL select zero-saturating behaviour.
REQ-028 Defined: counting at Q=0 SHALL hold Q=0 and never pulse BORROW; REQ-015 recovery still applies; TC unchanged.
REQ-029 Undefined (default): wrap behaviour per REQ-014.
REQ-030 Port list SHALL be identical in both builds.

Verification
REQ-031 CLR=1 one edge, then ENP=ENT=1 for 12 edges -> Q: 0,9,8,...,0,9,8; BORROW=1 only on the edge Q becomes 9 from 0; TC=1 while Q=0.
REQ-032 LOAD=1 PRE=7 with ENP=ENT=1 -> Q=7, BORROW=0; then LOAD=0 -> Q=6,5 on next edges.
REQ-033 Q=3, ENP=0 ENT=1 for 5 edges -> Q holds 3; ENT=0 ENP=1 -> holds 3; Q=0 ENT=0 -> TC=0.
REQ-034 LOAD PRE=13, then count -> Q=13 then 9, BORROW=0 throughout.
REQ-035 Q=0 counting, CLR=1 and LOAD=1 PRE=5 same edge -> Q=0, BORROW=0.
REQ-036 SATURATE_EN build: Q=1, count 4 edges -> Q=0,0,0,0; BORROW never asserted; TC=1 with ENT=1.

Source files
------------

// File: rtl/bcd_down_counter.sv
// Single-digit BCD down counter with parallel load, cascade enables, terminal
// count and wrap pulse. Define BCD_DOWN_COUNTER_SATURATE_EN to stop at zero.
module bcd_down_counter (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       LOAD,
  input  logic       ENP,
  input  logic       ENT,
  input  logic [3:0] PRE,
  output logic [3:0] Q,
  output logic       TC,
  output logic       BORROW
);

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_COUNT,
    OP_LOAD
  } op_e;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  op_e        op;
  logic [3:0] q_next;
  logic       borrow_next;

  // Load wins over count; clear is handled in the register itself.
  always_comb begin
    if (LOAD)            op = OP_LOAD;
    else if (ENP && ENT) op = OP_COUNT;
    else                 op = OP_HOLD;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    q_next      = Q;
    borrow_next = 1'b0;
    case (op)
      OP_LOAD: q_next = PRE;
      OP_COUNT: begin
        if (Q == 4'd0) begin
`ifdef BCD_DOWN_COUNTER_SATURATE_EN
          q_next      = 4'd0;
`else
          q_next      = DIGIT_MAX;
          borrow_next = 1'b1;
`endif
        end else if (Q > DIGIT_MAX) begin
          // Non-BCD codes recover straight to 9 without signalling a wrap.
          q_next = DIGIT_MAX;
        end else begin
          q_next = Q - 4'd1;
        end
      end
      default: q_next = Q;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (CLR) begin
      Q      <= 4'd0;
      BORROW <= 1'b0;
    end else begin
      Q      <= q_next;
      BORROW <= borrow_next;
    end
  end

  // Borrow-ahead for the next stage; deliberately unregistered.
  assign TC = ENT & (Q == 4'd0);

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter: directed steps, scoreboard queue of
// expected Q/BORROW, immediate TC checks before each edge.
module tb_bcd_down_counter;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic       LOAD = 1'b0;
  logic       ENP = 1'b0;
  logic       ENT = 1'b0;
  logic [3:0] PRE = 4'd0;
  logic [3:0] Q;
  logic       TC;
  logic       BORROW;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] q;
    logic       borrow;
    string      tag;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] model_q = 4'd0;
  logic       model_valid = 1'b0;

  bcd_down_counter dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .LOAD   (LOAD),
    .ENP    (ENP),
    .ENT    (ENT),
    .PRE    (PRE),
    .Q      (Q),
    .TC     (TC),
    .BORROW (BORROW)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of inputs, check TC before the edge, Q/BORROW after it.
  task automatic step(input logic clr, input logic load, input logic enp,
                      input logic ent, input logic [3:0] pre, input string tag);
    exp_t       e;
    exp_t       got;
    logic       exp_tc;
    logic [3:0] nq;
    logic       nb;
    CLR = clr; LOAD = load; ENP = enp; ENT = ent; PRE = pre;
    #1;
    if (model_valid) begin
      exp_tc = ent && (model_q == 4'd0);
      vectors++;
      assert (TC === exp_tc) else begin
        miscompares++;
        $error("FAIL %s_tc: TC=%b expected %b", tag, TC, exp_tc);
      end
    end
    nb = 1'b0;
    nq = model_q;
    if (clr) nq = 4'd0;
    else if (load) nq = pre;
    else if (enp && ent) begin
      if (model_q == 4'd0) begin
`ifdef BCD_DOWN_COUNTER_SATURATE_EN
        nq = 4'd0;
`else
        nq = 4'd9;
        nb = 1'b1;
`endif
      end else if (model_q >= 4'd10) nq = 4'd9;
      else nq = model_q - 4'd1;
    end
    model_q = nq;
    if (clr) model_valid = 1'b1;
    e.q = nq; e.borrow = nb; e.tag = tag;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    got = sb.pop_front();
    vectors++;
    assert (Q === got.q) else begin
      miscompares++;
      $error("FAIL %s_q: Q=%0d expected %0d", got.tag, Q, got.q);
    end
    vectors++;
    assert (BORROW === got.borrow) else begin
      miscompares++;
      $error("FAIL %s_borrow: BORROW=%b expected %b", got.tag, BORROW, got.borrow);
    end
  endtask

  initial begin
    @(posedge CLK);
    #1;
    // Reset, then twelve counts through a wrap.
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "reset");
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, "idle_tc");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, "count12");
    // Load beats count, then resume counting.
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd7, "load7");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, "after_load_a");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, "after_load_b");
    // Hold with either enable low.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, "load3");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, "hold_enp0");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, "hold_ent0");
    // TC gated by ENT at zero; load at zero still shows TC.
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, "clr_ent0");
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, "zero_ent0");
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, "load_at_zero");
    // Illegal codes load verbatim and recover to 9.
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd13, "load13");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, "recover13");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, "after13");
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd15, "load15");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, "recover15");
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd10, "load10");
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, "recover10");
    // Clear beats load and count at zero.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, "load0");
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, "clr_over_load");
    // Clear aborts a pending wrap.
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, "clr_abort_wrap");
    // Count from 1 across zero (wrap or saturate per build).
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd1, "load1");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, "from1");
    // Long run: consecutive wraps each pulse once.
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd2, "load2");
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, "long_run");
    // Random mix (clear rare).
    for (int i = 0; i < 60; i++) begin
      logic [3:0] r_pre;
      r_pre = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_pre, "random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
